inst_fetch: RTL and testbench

Instruction-fetch stage: owns the program counter, issues word reads on the instruction bus with a req/ack handshake, and drives the fetch-side outputs (`if_pc`, `if_inst`) into the IF/ID pipeline register. Implements MIPS delay-slot redirect: a taken branch changes the address fetched after the in-flight (delay-slot) fetch. Absorbs pipeline stalls with a one-entry buffer so that a bus transaction is never abandoned.

---
 rtl/inst_fetch_pkg.sv | 19 +
 rtl/inst_fetch.sv | 188 ++++++++++++++++++
 tb/tb_inst_fetch.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared widths, FSM state encoding and PC helper for the instruction-fetch stage.
package inst_fetch_pkg;

  localparam int unsigned INST_ADDR_W = 32;
  localparam int unsigned INST_W      = 32;

  localparam logic [INST_W-1:0] ZERO_WORD = '0;

  typedef enum logic [1:0] {
    IF_IDLE = 2'd0,
    IF_REQ  = 2'd1,
    IF_HOLD = 2'd2
  } if_state_e;

  function automatic logic [INST_ADDR_W-1:0] pc_step(input logic [INST_ADDR_W-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: PC, req/ack bus fetch, delay-slot redirect, one-entry stall buffer.
// Optional alignment trap enabled by defining IF_ALIGN_CHECK_EN (adds port if_adel).
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [INST_ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   branch_flag,
  input  logic [INST_ADDR_W-1:0] branch_target,
  output logic                   ibus_req,
  output logic [INST_ADDR_W-1:0] ibus_addr,
  input  logic                   ibus_ack,
  input  logic [INST_W-1:0]      ibus_rdata,
  output logic [INST_ADDR_W-1:0] if_pc,
  output logic [INST_W-1:0]      if_inst,
  output logic                   if_valid
`ifdef IF_ALIGN_CHECK_EN
  ,
  output logic                   if_adel
`endif
);

  if_state_e              state_q, state_d;
  logic [INST_ADDR_W-1:0] pc_q, pc_d;
  logic [INST_W-1:0]      buf_inst_q, buf_inst_d;
  logic [INST_ADDR_W-1:0] buf_pc_q, buf_pc_d;
  logic                   redir_vld_q, redir_vld_d;
  logic [INST_ADDR_W-1:0] redir_pc_q, redir_pc_d;
  logic [INST_ADDR_W-1:0] if_pc_q, if_pc_d;
  logic [INST_W-1:0]      if_inst_q, if_inst_d;
  logic                   if_valid_q, if_valid_d;

  logic                   redir_hit;
  logic [INST_ADDR_W-1:0] redir_tgt;
  logic [INST_ADDR_W-1:0] next_pc;
  logic                   redir_consumed;

`ifdef IF_ALIGN_CHECK_EN
  logic if_adel_q, if_adel_d;
  logic adel_wait_q, adel_wait_d;
  logic pc_misaligned;

  assign pc_misaligned = (pc_q[1:0] != 2'b00);
  assign ibus_req      = (state_q == IF_REQ) && !pc_misaligned;
  assign ibus_addr     = pc_q;
  assign if_adel       = if_adel_q;
`else
  assign ibus_req      = (state_q == IF_REQ);
  assign ibus_addr     = {pc_q[INST_ADDR_W-1:2], 2'b00};
`endif

  assign if_pc    = if_pc_q;
  assign if_inst  = if_inst_q;
  assign if_valid = if_valid_q;

  // A flag arriving this cycle overrides an older pending redirect (last wins).
  assign redir_hit = branch_flag | redir_vld_q;
  assign redir_tgt = branch_flag ? branch_target : redir_pc_q;
  assign next_pc   = redir_hit ? redir_tgt : pc_step(pc_q);

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    buf_inst_d     = buf_inst_q;
    buf_pc_d       = buf_pc_q;
    redir_vld_d    = redir_vld_q;
    redir_pc_d     = redir_pc_q;
    if_pc_d        = if_pc_q;
    if_inst_d      = if_inst_q;
    if_valid_d     = if_valid_q;
    redir_consumed = 1'b0;
`ifdef IF_ALIGN_CHECK_EN
    if_adel_d      = if_adel_q;
    adel_wait_d    = adel_wait_q;
`endif

    unique case (state_q)
      IF_IDLE: begin
`ifdef IF_ALIGN_CHECK_EN
        if (!adel_wait_q) begin
          state_d = IF_REQ;
        end else if (redir_hit) begin
          pc_d           = redir_tgt;
          redir_vld_d    = 1'b0;
          redir_consumed = 1'b1;
          adel_wait_d    = 1'b0;
          state_d        = IF_REQ;
        end
`else
        state_d = IF_REQ;
`endif
      end

      IF_REQ: begin
`ifdef IF_ALIGN_CHECK_EN
        if (pc_misaligned) begin
          if (!stall) begin
            if_pc_d     = pc_q;
            if_inst_d   = ZERO_WORD;
            if_valid_d  = 1'b1;
            if_adel_d   = 1'b1;
            adel_wait_d = 1'b1;
            state_d     = IF_IDLE;
          end
        end else
`endif
        if (ibus_ack) begin
          pc_d           = next_pc;
          redir_vld_d    = 1'b0;
          redir_consumed = 1'b1;
          if (!stall) begin
            if_pc_d    = pc_q;
            if_inst_d  = ibus_rdata;
            if_valid_d = 1'b1;
`ifdef IF_ALIGN_CHECK_EN
            if_adel_d  = 1'b0;
`endif
          end else begin
            buf_inst_d = ibus_rdata;
            buf_pc_d   = pc_q;
            state_d    = IF_HOLD;
          end
        end else if (!stall) begin
          if_inst_d  = ZERO_WORD;
          if_valid_d = 1'b0;
`ifdef IF_ALIGN_CHECK_EN
          if_adel_d  = 1'b0;
`endif
        end
      end

      IF_HOLD: begin
        if (!stall) begin
          if_pc_d    = buf_pc_q;
          if_inst_d  = buf_inst_q;
          if_valid_d = 1'b1;
`ifdef IF_ALIGN_CHECK_EN
          if_adel_d  = 1'b0;
`endif
          state_d    = IF_REQ;
        end
      end

      default: state_d = IF_IDLE;
    endcase

    if (branch_flag && !redir_consumed) begin
      redir_vld_d = 1'b1;
      redir_pc_d  = branch_target;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IF_IDLE;
      pc_q        <= RESET_PC;
      buf_inst_q  <= '0;
      buf_pc_q    <= '0;
      redir_vld_q <= 1'b0;
      redir_pc_q  <= '0;
      if_pc_q     <= '0;
      if_inst_q   <= '0;
      if_valid_q  <= 1'b0;
`ifdef IF_ALIGN_CHECK_EN
      if_adel_q   <= 1'b0;
      adel_wait_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      buf_inst_q  <= buf_inst_d;
      buf_pc_q    <= buf_pc_d;
      redir_vld_q <= redir_vld_d;
      redir_pc_q  <= redir_pc_d;
      if_pc_q     <= if_pc_d;
      if_inst_q   <= if_inst_d;
      if_valid_q  <= if_valid_d;
`ifdef IF_ALIGN_CHECK_EN
      if_adel_q   <= if_adel_d;
      adel_wait_q <= adel_wait_d;
`endif
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: a program-order fetch model feeds an expected queue,
// a separate monitor pops and compares each instruction the stage presents.
module tb_inst_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic        ibus_req;
  logic [31:0] ibus_addr;
  logic        ibus_ack;
  logic [31:0] ibus_rdata;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid;

  inst_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .branch_flag  (branch_flag),
    .branch_target(branch_target),
    .ibus_req     (ibus_req),
    .ibus_addr    (ibus_addr),
    .ibus_ack     (ibus_ack),
    .ibus_rdata   (ibus_rdata),
    .if_pc        (if_pc),
    .if_inst      (if_inst),
    .if_valid     (if_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_t;

  fetch_t      exp_q[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Program-order reference: next address to fetch and the outstanding redirect.
  logic [31:0] model_pc;
  logic        pend_vld;
  logic [31:0] pend_pc;
  int unsigned wait_left;
  logic        prev_ack_stall;
  bit          mon_en;
  bit          br_done;
  int unsigned cyc;

  logic [31:0] snap_pc, snap_inst;
  logic        snap_valid;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Called just after a falling edge; inputs set here are sampled at the next rising edge.
  task automatic drive(input logic st, input logic br, input logic [31:0] tgt,
                       input int unsigned lat_lo, input int unsigned lat_hi, input logic ack_en);
    if (prev_ack_stall) chk("req_drop_after_stalled_ack", 32'(ibus_req), 32'd0);
    prev_ack_stall = 1'b0;
    stall          = st;
    branch_flag    = br;
    branch_target  = tgt;
    if (br) begin
      pend_vld = 1'b1;
      pend_pc  = tgt;
    end
    ibus_ack   = 1'b0;
    ibus_rdata = $urandom;
    if (ibus_req) begin
      chk("ibus_addr", ibus_addr, model_pc);
      if (ack_en && wait_left == 0) begin
        ibus_ack   = 1'b1;
        ibus_rdata = mem_word(ibus_addr);
        exp_q.push_back('{model_pc, mem_word(model_pc)});
        model_pc       = pend_vld ? pend_pc : model_pc + 32'd4;
        pend_vld       = 1'b0;
        wait_left      = $urandom_range(lat_hi, lat_lo);
        prev_ack_stall = st;
      end else if (wait_left != 0) begin
        wait_left--;
      end
    end
  endtask

  // Monitor: every unstalled edge that leaves if_valid high is a new delivery.
  initial begin
    fetch_t e;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        cyc++;
        if (cyc == 1) begin
          chk("req_on_cycle1", 32'(ibus_req), 32'd1);
          chk("invalid_on_cycle1", 32'(if_valid), 32'd0);
        end
        if (cyc == 2) chk("valid_on_cycle2", 32'(if_valid), 32'd1);
        if (stall) begin
          chk("stall_hold_pc", if_pc, snap_pc);
          chk("stall_hold_inst", if_inst, snap_inst);
          chk("stall_hold_valid", 32'(if_valid), 32'(snap_valid));
        end else if (if_valid) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_delivery: got pc %h, expected no instruction", if_pc);
          end else begin
            e = exp_q.pop_front();
            chk("if_pc", if_pc, e.pc);
            chk("if_inst", if_inst, e.inst);
          end
        end
        if (!if_valid) chk("nop_when_invalid", if_inst, 32'd0);
        snap_pc    = if_pc;
        snap_inst  = if_inst;
        snap_valid = if_valid;
      end
    end
  end

  initial begin
    rst = 1'b0; stall = 1'b0; branch_flag = 1'b0; branch_target = '0;
    ibus_ack = 1'b0; ibus_rdata = '0;
    model_pc = RESET_PC; pend_vld = 1'b0; pend_pc = '0; wait_left = 0;
    prev_ack_stall = 1'b0; mon_en = 1'b0; br_done = 1'b0; cyc = 0;
    snap_pc = '0; snap_inst = '0; snap_valid = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_ibus_req", 32'(ibus_req), 32'd0);
    chk("rst_ibus_addr", ibus_addr, RESET_PC);
    chk("rst_if_pc", if_pc, 32'd0);
    chk("rst_if_inst", if_inst, 32'd0);
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    rst    = 1'b1;
    mon_en = 1'b1;

    // zero-wait stream, then a branch to 0x100 while 0x10 is on the bus
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(1'b0, ibus_req && ibus_addr == 32'h10, 32'h100, 0, 0, 1'b1);
    end

    // three wait states per fetch; one branch flagged mid-wait
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      drive(1'b0, ibus_req && wait_left == 1 && !br_done, 32'h200, 3, 3, 1'b1);
      if (branch_flag) br_done = 1'b1;
    end

    // five stalled cycles spanning an ack
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      drive(i >= 3 && i < 8, 1'b0, 32'h0, 0, 0, 1'b1);
    end

    // PC wrap-around past the top of the address space
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(1'b0, i == 0, 32'hFFFF_FFF4, 0, 0, 1'b1);
    end

    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      drive($urandom_range(3, 0) == 0, $urandom_range(9, 0) == 0,
            32'($urandom_range(255, 0)) << 2, 0, 3, 1'b1);
    end

    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive(1'b0, 1'b0, 32'h0, 0, 0, 1'b0);
    end
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    // asynchronous reset while a request is outstanding
    @(negedge clk);
    mon_en = 1'b0;
    chk("req_before_reset", 32'(ibus_req), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_req", 32'(ibus_req), 32'd0);
    chk("async_rst_valid", 32'(if_valid), 32'd0);
    chk("async_rst_addr", ibus_addr, RESET_PC);
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
